// File: rtl/button_uart_reporter_if.sv
// Byte handshake between the button reporter and the uart_usb transmitter.
// The reporter presents a byte with a one-cycle load strobe and watches busy.
interface button_uart_reporter_if;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_busy;

  modport master (
    output tx_data,
    output tx_load,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_load,
    output tx_busy
  );
endinterface

// File: rtl/button_uart_reporter.sv
// Button reporter: debounces four raw buttons, turns each accepted press into
// the ASCII message "B<idx>\r\n", queues the bytes in a small FIFO and feeds
// them to the uart transmitter through a load/busy handshake.
module button_uart_reporter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int BUSY_WAIT       = 4
) (
  input  logic                          clk_50,
  input  logic                          reset,
  input  logic [3:0]                    buttons_num,
  button_uart_reporter_if.master        tx,
  output logic [3:0]                    press_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [3:0]    IDLE_LEVEL = BTN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BUSY_LAST  = BW'(BUSY_WAIT - 1);
  localparam logic [AW:0]   DEPTH_V    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   MSG_LEN    = (AW + 1)'(4);

  typedef enum logic [2:0] {
    WR_IDLE = 3'd0,
    WR_W0   = 3'd1,
    WR_W1   = 3'd2,
    WR_W2   = 3'd3,
    WR_W3   = 3'd4
  } wr_state_t;

  typedef enum logic [1:0] {
    DR_IDLE      = 2'd0,
    DR_LOAD      = 2'd1,
    DR_WAIT_BUSY = 2'd2,
    DR_WAIT_DONE = 2'd3
  } dr_state_t;

  // input stage
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    w_level;
  logic [3:0]    r_deb;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_press_pulse;

  // pending / drop accounting
  logic [3:0]    r_pending;
  logic [3:0]    w_clear;
  logic [3:0]    w_drop_bits;
  logic [2:0]    w_drop_n;
  logic [8:0]    w_drop_sum;
  logic [7:0]    w_drop_next;
  logic [7:0]    r_drop;

  // writer
  wr_state_t     r_wr_state;
  wr_state_t     w_wr_next;
  logic [1:0]    w_pick;
  logic [1:0]    r_sel;
  logic          w_wr_en;
  logic [7:0]    w_wr_byte;
  logic [AW:0]   w_free;

  // fifo
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    w_head;
  logic          w_empty;

  // drain
  dr_state_t     r_dr_state;
  dr_state_t     w_dr_next;
  logic [BW-1:0] r_wait_cnt;
  logic          w_rd_en;
  logic          w_load_next;
  logic [7:0]    r_tx_data;
  logic          r_tx_load;

  // Two-flop synchronizer; resets to the released pin level so no false press.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= buttons_num;
      r_sync2 <= r_sync1;
    end
  end

  // 1 means pressed regardless of pin polarity.
  assign w_level = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // Per-button stability counter; flips the debounced level and pulses on press.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_deb         <= 4'b0000;
      r_press_pulse <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      r_press_pulse <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (w_level[i] == r_deb[i]) begin
          r_cnt[i] <= {CW{1'b0}};
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i]         <= w_level[i];
          r_cnt[i]         <= {CW{1'b0}};
          r_press_pulse[i] <= w_level[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Presses that land on a still-pending button are lost; count them, saturating.
  always_comb begin
    w_drop_bits = r_press_pulse & r_pending & ~w_clear;
    w_drop_n    = {2'b00, w_drop_bits[0]} + {2'b00, w_drop_bits[1]}
                + {2'b00, w_drop_bits[2]} + {2'b00, w_drop_bits[3]};
    w_drop_sum  = {1'b0, r_drop} + {6'b000000, w_drop_n};
    if (w_drop_sum > 9'd255) begin
      w_drop_next = 8'hFF;
    end else begin
      w_drop_next = w_drop_sum[7:0];
    end
  end

  // Pending flags and drop counter.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_pending <= 4'b0000;
      r_drop    <= 8'h00;
    end else begin
      r_pending <= (r_pending & ~w_clear) | r_press_pulse;
      r_drop    <= w_drop_next;
    end
  end

  // Lowest-index pending button wins.
  always_comb begin
    if (r_pending[0]) begin
      w_pick = 2'd0;
    end else if (r_pending[1]) begin
      w_pick = 2'd1;
    end else if (r_pending[2]) begin
      w_pick = 2'd2;
    end else begin
      w_pick = 2'd3;
    end
  end

  assign w_free = DEPTH_V - r_count;

  // Writer state register.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_wr_state <= WR_IDLE;
    end else begin
      r_wr_state <= w_wr_next;
    end
  end

  // Writer next state: start a message only when all four bytes fit.
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: begin
        if ((r_pending != 4'b0000) && (w_free >= MSG_LEN)) begin
          w_wr_next = WR_W0;
        end else begin
          w_wr_next = WR_IDLE;
        end
      end
      WR_W0:   w_wr_next = WR_W1;
      WR_W1:   w_wr_next = WR_W2;
      WR_W2:   w_wr_next = WR_W3;
      WR_W3:   w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

  // Writer outputs: byte to push and the pending bit consumed on message start.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_byte = 8'h00;
    w_clear   = 4'b0000;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_wr_next == WR_W0) begin
          w_clear = 4'b0001 << w_pick;
        end else begin
          w_clear = 4'b0000;
        end
      end
      WR_W0: begin
        w_wr_en   = 1'b1;
        w_wr_byte = 8'h42;
      end
      WR_W1: begin
        w_wr_en   = 1'b1;
        w_wr_byte = 8'h30 + {6'b000000, r_sel};
      end
      WR_W2: begin
        w_wr_en   = 1'b1;
        w_wr_byte = 8'h0D;
      end
      WR_W3: begin
        w_wr_en   = 1'b1;
        w_wr_byte = 8'h0A;
      end
      default: begin
        w_wr_en   = 1'b0;
        w_wr_byte = 8'h00;
      end
    endcase
  end

  // Remember which button the current message belongs to.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_sel <= 2'd0;
    end else if ((r_wr_state == WR_IDLE) && (w_wr_next == WR_W0)) begin
      r_sel <= w_pick;
    end else begin
      r_sel <= r_sel;
    end
  end

  // FIFO storage; contents are don't-care once pointers reset.
  always_ff @(posedge clk_50) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_byte;
    end
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign w_empty = (r_count == {(AW + 1){1'b0}});

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW + 1){1'b0}};
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain state register.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_dr_state <= DR_IDLE;
    end else begin
      r_dr_state <= w_dr_next;
    end
  end

  // Drain next state: pop, strobe, wait for busy to rise (bounded), wait for idle.
  always_comb begin
    w_dr_next = r_dr_state;
    case (r_dr_state)
      DR_IDLE: begin
        if (!w_empty && !tx.tx_busy) begin
          w_dr_next = DR_LOAD;
        end else begin
          w_dr_next = DR_IDLE;
        end
      end
      DR_LOAD: w_dr_next = DR_WAIT_BUSY;
      DR_WAIT_BUSY: begin
        if (tx.tx_busy || (r_wait_cnt == BUSY_LAST)) begin
          w_dr_next = DR_WAIT_DONE;
        end else begin
          w_dr_next = DR_WAIT_BUSY;
        end
      end
      DR_WAIT_DONE: begin
        if (!tx.tx_busy) begin
          w_dr_next = DR_IDLE;
        end else begin
          w_dr_next = DR_WAIT_DONE;
        end
      end
      default: w_dr_next = DR_IDLE;
    endcase
  end

  // Drain outputs: pop on leaving IDLE, load strobe registered from next state.
  always_comb begin
    w_rd_en     = 1'b0;
    w_load_next = 1'b0;
    case (r_dr_state)
      DR_IDLE: begin
        w_rd_en     = (w_dr_next == DR_LOAD);
        w_load_next = (w_dr_next == DR_LOAD);
      end
      default: begin
        w_rd_en     = 1'b0;
        w_load_next = 1'b0;
      end
    endcase
  end

  // Cycles spent waiting for busy to rise after a load.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= {BW{1'b0}};
    end else if (r_dr_state == DR_WAIT_BUSY) begin
      r_wait_cnt <= r_wait_cnt + BW'(1);
    end else begin
      r_wait_cnt <= {BW{1'b0}};
    end
  end

  // Registered transmitter interface; data holds until the next pop.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_tx_data <= 8'h00;
      r_tx_load <= 1'b0;
    end else begin
      r_tx_load <= w_load_next;
      if (w_rd_en) begin
        r_tx_data <= w_head;
      end else begin
        r_tx_data <= r_tx_data;
      end
    end
  end

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_load  = r_tx_load;
  assign press_pulse = r_press_pulse;
  assign fifo_count  = r_count;
  assign drop_count  = r_drop;

endmodule

// File: tb/tb_button_uart_reporter.sv
// Directed bench for button_uart_reporter with a small transmitter model.
module tb_button_uart_reporter;

  localparam int DEB   = 4;
  localparam int DEPTH = 16;
  localparam int BWAIT = 4;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic [3:0] buttons_num;
  logic [3:0] press_pulse;
  logic [4:0] fifo_count;
  logic [7:0] drop_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // transmitter model: 0 = busy 10 cycles per load, 1 = always busy, 2 = never busy
  int         mode = 0;
  int         busy_left = 0;
  int         cyc = 0;
  logic [7:0] got [$];
  int         load_t [$];
  int         pulse_cnt [4] = '{0, 0, 0, 0};

  button_uart_reporter_if u_if ();

  button_uart_reporter #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH(DEPTH),
    .BTN_ACTIVE_LOW(1'b1),
    .BUSY_WAIT(BWAIT)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .buttons_num(buttons_num),
    .tx(u_if.master),
    .press_pulse(press_pulse),
    .fifo_count(fifo_count),
    .drop_count(drop_count)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc++;

  // Monitor loads and pulses; drive tx_busy away from the active edge.
  always @(negedge clk_50) begin
    if (u_if.tx_load === 1'b1) begin
      got.push_back(u_if.tx_data);
      load_t.push_back(cyc);
      if (mode == 0) busy_left = 10;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    for (int i = 0; i < 4; i++) begin
      if (press_pulse[i] === 1'b1) pulse_cnt[i]++;
    end
    u_if.tx_busy = (mode == 1) || ((mode == 0) && (busy_left > 0));
  end

  task automatic wait_loads(input int n, input int budget);
    int k;
    k = 0;
    while ((got.size() < n) && (k < budget)) begin
      @(negedge clk_50);
      k++;
    end
    chk_cnt++;
    if (got.size() < n) $display("FAIL wait_loads: got %0d loads, required %0d", got.size(), n);
    else pass_cnt++;
  endtask

  task automatic press_release(input int btn, input int hold);
    buttons_num = 4'hF & ~(4'b0001 << btn);
    repeat (hold) @(negedge clk_50);
    buttons_num = 4'hF;
    repeat (hold) @(negedge clk_50);
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1;
    buttons_num = 4'hF;
    mode = 0;
    repeat (3) @(negedge clk_50);
    chk_cnt++;
    if ({u_if.tx_data, u_if.tx_load, press_pulse, fifo_count, drop_count} !== 26'd0)
      $display("FAIL reset_values: got %h, required 0",
               {u_if.tx_data, u_if.tx_load, press_pulse, fifo_count, drop_count});
    else pass_cnt++;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50);
      if ({u_if.tx_data, u_if.tx_load, press_pulse, fifo_count, drop_count} !== 26'd0) bad++;
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL idle_outputs: %0d nonzero cycles, required 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if (got.size() !== 0) $display("FAIL idle_loads: got %0d, required 0", got.size());
    else pass_cnt++;
  endtask

  task automatic test_clean_press;
    int b, p;
    logic [7:0] exp_b [4];
    exp_b = '{8'h42, 8'h32, 8'h0D, 8'h0A};
    mode = 0;
    b = got.size();
    p = pulse_cnt[2];
    buttons_num = 4'b1011;
    repeat (5) @(negedge clk_50);
    chk_cnt++;
    if (press_pulse !== 4'b0000) $display("FAIL press_early: got %b, required 0000", press_pulse);
    else pass_cnt++;
    @(negedge clk_50);
    chk_cnt++;
    if (press_pulse !== 4'b0100) $display("FAIL press_latency: got %b, required 0100", press_pulse);
    else pass_cnt++;
    wait_loads(b + 4, 300);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (got[b + i] !== exp_b[i]) $display("FAIL clean_byte%0d: got %h, required %h", i, got[b + i], exp_b[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (fifo_count !== 5'd0) $display("FAIL clean_fifo_empty: got %0d, required 0", fifo_count);
    else pass_cnt++;
    buttons_num = 4'hF;
    repeat (15) @(negedge clk_50);
    chk_cnt++;
    if (pulse_cnt[2] - p !== 1) $display("FAIL clean_pulse_count: got %0d, required 1", pulse_cnt[2] - p);
    else pass_cnt++;
  endtask

  task automatic test_bounce;
    int b, p;
    logic [7:0] exp_b [4];
    exp_b = '{8'h42, 8'h30, 8'h0D, 8'h0A};
    mode = 0;
    b = got.size();
    p = pulse_cnt[0];
    for (int k = 0; k < 10; k++) begin
      buttons_num = (k % 2 == 0) ? 4'hE : 4'hF;
      repeat (2) @(negedge clk_50);
    end
    buttons_num = 4'hE;
    repeat (20) @(negedge clk_50);
    chk_cnt++;
    if (pulse_cnt[0] - p !== 1) $display("FAIL bounce_pulses: got %0d, required 1", pulse_cnt[0] - p);
    else pass_cnt++;
    wait_loads(b + 4, 300);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (got[b + i] !== exp_b[i]) $display("FAIL bounce_byte%0d: got %h, required %h", i, got[b + i], exp_b[i]);
      else pass_cnt++;
    end
    buttons_num = 4'hF;
    repeat (15) @(negedge clk_50);
  endtask

  task automatic test_simultaneous;
    int b;
    logic [7:0] exp_b [8];
    exp_b = '{8'h42, 8'h31, 8'h0D, 8'h0A, 8'h42, 8'h33, 8'h0D, 8'h0A};
    mode = 0;
    b = got.size();
    buttons_num = 4'b0101;
    repeat (12) @(negedge clk_50);
    buttons_num = 4'hF;
    wait_loads(b + 8, 400);
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (got[b + i] !== exp_b[i]) $display("FAIL simul_byte%0d: got %h, required %h", i, got[b + i], exp_b[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (drop_count !== 8'd0) $display("FAIL simul_drop: got %0d, required 0", drop_count);
    else pass_cnt++;
  endtask

  task automatic test_fifo_full;
    int p;
    mode = 1;
    p = pulse_cnt[0];
    repeat (2) @(negedge clk_50);
    for (int i = 0; i < 4; i++) press_release(0, 12);
    chk_cnt++;
    if (fifo_count !== 5'd16) $display("FAIL full_count: got %0d, required 16", fifo_count);
    else pass_cnt++;
    press_release(0, 12);
    chk_cnt++;
    if ({fifo_count, drop_count} !== {5'd16, 8'd0})
      $display("FAIL fifth_press: got count %0d drop %0d, required 16 and 0", fifo_count, drop_count);
    else pass_cnt++;
    press_release(0, 12);
    chk_cnt++;
    if (drop_count !== 8'd1) $display("FAIL sixth_drop: got %0d, required 1", drop_count);
    else pass_cnt++;
    chk_cnt++;
    if (fifo_count !== 5'd16) $display("FAIL sixth_count: got %0d, required 16", fifo_count);
    else pass_cnt++;
    chk_cnt++;
    if (pulse_cnt[0] - p !== 6) $display("FAIL full_pulses: got %0d, required 6", pulse_cnt[0] - p);
    else pass_cnt++;
  endtask

  task automatic test_never_busy_reset;
    int b, n, k;
    logic [7:0] exp_b [4];
    exp_b = '{8'h42, 8'h30, 8'h0D, 8'h0A};
    b = got.size();
    mode = 2;
    wait_loads(b + 6, 400);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (got[b + i] !== exp_b[i]) $display("FAIL nobusy_byte%0d: got %h, required %h", i, got[b + i], exp_b[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      chk_cnt++;
      if (load_t[b + i + 1] - load_t[b + i] < BWAIT + 1)
        $display("FAIL nobusy_spacing%0d: got %0d cycles, required at least %0d",
                 i, load_t[b + i + 1] - load_t[b + i], BWAIT + 1);
      else pass_cnt++;
    end
    k = 0;
    while ((u_if.tx_load !== 1'b1) && (k < 50)) begin
      @(negedge clk_50);
      k++;
    end
    chk_cnt++;
    if (u_if.tx_load !== 1'b1) $display("FAIL midmsg_load_seen: got %b, required 1", u_if.tx_load);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if (u_if.tx_load !== 1'b0) $display("FAIL reset_load_drop: got %b, required 0", u_if.tx_load);
    else pass_cnt++;
    chk_cnt++;
    if (fifo_count !== 5'd0) $display("FAIL reset_fifo: got %0d, required 0", fifo_count);
    else pass_cnt++;
    chk_cnt++;
    if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d, required 0", drop_count);
    else pass_cnt++;
    @(negedge clk_50);
    reset = 1'b0;
    n = got.size();
    repeat (100) @(negedge clk_50);
    chk_cnt++;
    if (got.size() !== n) $display("FAIL post_reset_loads: got %0d, required 0", got.size() - n);
    else pass_cnt++;
    chk_cnt++;
    if (fifo_count !== 5'd0) $display("FAIL post_reset_fifo: got %0d, required 0", fifo_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_fifo_full();
    test_never_busy_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
